// File: rtl/pid_ctrl_pipe.sv
// Three-stage pipelined PID controller: error/derivative/integrator, gain products, sum-shift-saturate.
// Keeps its own previous-error and anti-windup-clamped integrator state; one sample per cycle.
module pid_ctrl_pipe #(
    parameter int DW   = 16,
    parameter int KW   = 8,
    parameter int OW   = 16,
    parameter int FRAC = 0,
    parameter int IMAX = 1000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] setpoint,
    input  logic signed [DW-1:0] feedback,
    input  logic signed [KW-1:0] kp,
    input  logic signed [KW-1:0] ki,
    input  logic signed [KW-1:0] kd,
    output logic                 out_valid,
    output logic signed [OW-1:0] ctrl_out,
    output logic                 out_sat
);

    localparam int PW = DW + KW;
    localparam int SW = DW + KW + 3;

    localparam logic signed [DW:0]   IMAX_POS = (DW+1)'(IMAX);
    localparam logic signed [DW:0]   IMAX_NEG = -IMAX_POS;
    localparam logic signed [DW-1:0] E_MAX    = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] E_MIN    = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [OW-1:0] O_MAX    = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] O_MIN    = {1'b1, {(OW-1){1'b0}}};

    // Controller state
    logic signed [DW-1:0] integ_q, integ_d;
    logic signed [DW-1:0] e_prev_q, e_prev_d;
    logic                 first_q, first_d;

    // Stage 1 registers
    logic                 v1_q, v1_d;
    logic signed [DW-1:0] e1_q, e1_d;
    logic signed [DW:0]   de1_q, de1_d;
    logic signed [DW-1:0] integ1_q, integ1_d;

    // Stage 2 registers
    logic                 v2_q, v2_d;
    logic signed [PW-1:0] p2_q, p2_d;
    logic signed [PW-1:0] i2_q, i2_d;
    logic signed [PW:0]   d2_q, d2_d;

    // Stage 3 / output registers
    logic                 out_valid_q, out_valid_d;
    logic signed [OW-1:0] ctrl_out_q, ctrl_out_d;
    logic                 out_sat_q, out_sat_d;

    // Combinational datapath
    logic signed [DW:0]   diff_c;
    logic signed [DW-1:0] e_c;
    logic signed [DW:0]   de_c;
    logic signed [DW:0]   isum_c;
    logic signed [DW-1:0] iclamp_c;
    logic signed [PW-1:0] p_c;
    logic signed [PW-1:0] i_c;
    logic signed [PW:0]   d_c;
    logic signed [SW-1:0] sum_c;
    logic signed [SW-1:0] shift_c;
    logic                 clip_c;
    logic signed [OW-1:0] ctrl_c;

    // The difference is one bit wider than the inputs so it can be clipped rather than wrapped.
    always_comb begin
        diff_c = (DW+1)'(setpoint) - (DW+1)'(feedback);
        e_c    = diff_c[DW-1:0];
        if (diff_c[DW] != diff_c[DW-1]) begin
            e_c = diff_c[DW] ? E_MIN : E_MAX;
        end

        de_c = first_q ? '0 : ((DW+1)'(e_c) - (DW+1)'(e_prev_q));

        isum_c   = (DW+1)'(integ_q) + (DW+1)'(e_c);
        iclamp_c = isum_c[DW-1:0];
        if (isum_c > IMAX_POS) begin
            iclamp_c = IMAX_POS[DW-1:0];
        end else if (isum_c < IMAX_NEG) begin
            iclamp_c = IMAX_NEG[DW-1:0];
        end
    end

    always_comb begin
        p_c = PW'(kp) * PW'(e1_q);
        i_c = PW'(ki) * PW'(integ1_q);
        d_c = (PW+1)'(kd) * (PW+1)'(de1_q);
    end

    // Clipping is detected by the bits above the output sign not all matching it.
    always_comb begin
        sum_c   = SW'(p2_q) + SW'(i2_q) + SW'(d2_q);
        shift_c = sum_c >>> FRAC;
        clip_c  = (shift_c[SW-1:OW-1] != {(SW-OW+1){shift_c[SW-1]}});
        ctrl_c  = shift_c[OW-1:0];
        if (clip_c) begin
            ctrl_c = shift_c[SW-1] ? O_MIN : O_MAX;
        end
    end

    always_comb begin
        integ_d     = integ_q;
        e_prev_d    = e_prev_q;
        first_d     = first_q;
        e1_d        = e1_q;
        de1_d       = de1_q;
        integ1_d    = integ1_q;
        p2_d        = p2_q;
        i2_d        = i2_q;
        d2_d        = d2_q;
        ctrl_out_d  = ctrl_out_q;
        out_sat_d   = out_sat_q;

        v1_d        = in_valid && !clr;
        v2_d        = v1_q && !clr;
        out_valid_d = v2_q && !clr;

        // Clear wins over a sample arriving in the same cycle.
        if (clr) begin
            integ_d  = '0;
            e_prev_d = '0;
            first_d  = 1'b1;
        end else if (in_valid) begin
            integ_d  = iclamp_c;
            e_prev_d = e_c;
            first_d  = 1'b0;
            e1_d     = e_c;
            de1_d    = de_c;
            integ1_d = iclamp_c;
        end

        if (v2_d) begin
            p2_d = p_c;
            i2_d = i_c;
            d2_d = d_c;
        end

        if (out_valid_d) begin
            ctrl_out_d = ctrl_c;
            out_sat_d  = clip_c;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            integ_q     <= '0;
            e_prev_q    <= '0;
            first_q     <= 1'b1;
            v1_q        <= 1'b0;
            e1_q        <= '0;
            de1_q       <= '0;
            integ1_q    <= '0;
            v2_q        <= 1'b0;
            p2_q        <= '0;
            i2_q        <= '0;
            d2_q        <= '0;
            out_valid_q <= 1'b0;
            ctrl_out_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            e_prev_q    <= e_prev_d;
            first_q     <= first_d;
            v1_q        <= v1_d;
            e1_q        <= e1_d;
            de1_q       <= de1_d;
            integ1_q    <= integ1_d;
            v2_q        <= v2_d;
            p2_q        <= p2_d;
            i2_q        <= i2_d;
            d2_q        <= d2_d;
            out_valid_q <= out_valid_d;
            ctrl_out_q  <= ctrl_out_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ctrl_out  = ctrl_out_q;
    assign out_sat   = out_sat_q;

endmodule
